// File: rtl/osc_ctrl_pkg.sv
// Shared types for the ring-oscillator measurement sequencer: FSM states
// and oscillator-enable encodings.
package osc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_A,
    ST_GATE_A,
    ST_SETTLE_B,
    ST_GATE_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] OSC_NONE = 2'b00;
  localparam logic [1:0] OSC_A    = 2'b01;
  localparam logic [1:0] OSC_B    = 2'b10;

endpackage

// File: rtl/osc_edge_counter.sv
// Synchronizes one asynchronous oscillator tap, detects rising edges and
// counts them with saturation while enabled.
module osc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_nxt_o,
  output logic             ovf_nxt_o
);

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             edge_seen;

  assign edge_seen = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= osc_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: defaults first so every path assigns count_d/ovf_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i && edge_seen) begin
      // An edge arriving at all-ones is lost, which is what ovf reports.
      if (&count_q) ovf_d   = 1'b1;
      else          count_d = count_q + CNT_W'(1);
    end
  end

  // Next-state values let the sequencer latch results including an edge
  // seen in the final gate cycle.
  assign count_nxt_o = count_d;
  assign ovf_nxt_o   = ovf_d;

endmodule

// File: rtl/osc_measure_ctrl.sv
// Sequencer for the ring-oscillator pair: settle, gate and count A, then B,
// and publish both counts plus their signed difference.
module osc_measure_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 10000,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             osc_a,
  input  logic             osc_b,
  output logic [1:0]       osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [1:0]       ovf,
  output logic [CNT_W:0]   diff
);

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [1:0]       osc_en_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] count_a_q, count_b_q;
  logic [1:0]       ovf_q;
  logic [CNT_W:0]   diff_q;

  logic             timer_zero;
  logic             clr_a, clr_b, en_a, en_b;
  logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
  logic             ovf_a_nxt, ovf_b_nxt;

  assign timer_zero = (timer_q == '0);
  assign clr_a      = (state_q == ST_SETTLE_A) && timer_zero;
  assign clr_b      = (state_q == ST_SETTLE_B) && timer_zero;
  assign en_a       = (state_q == ST_GATE_A);
  assign en_b       = (state_q == ST_GATE_B);

  osc_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .osc_i       (osc_a),
    .clr_i       (clr_a),
    .en_i        (en_a),
    .count_nxt_o (cnt_a_nxt),
    .ovf_nxt_o   (ovf_a_nxt)
  );

  osc_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .osc_i       (osc_b),
    .clr_i       (clr_b),
    .en_i        (en_b),
    .count_nxt_o (cnt_b_nxt),
    .ovf_nxt_o   (ovf_b_nxt)
  );

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      osc_en_q  <= OSC_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_a_q <= '0;
      count_b_q <= '0;
      ovf_q     <= 2'b00;
      diff_q    <= '0;
    end else if (abort) begin
      state_q  <= ST_IDLE;
      osc_en_q <= OSC_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start || (state_q == ST_DONE && cont)) begin
            state_q  <= ST_SETTLE_A;
            timer_q  <= SETTLE_LD;
            osc_en_q <= OSC_A;
            busy_q   <= 1'b1;
          end
        end
        ST_SETTLE_A: begin
          if (timer_zero) begin
            state_q <= ST_GATE_A;
            timer_q <= GATE_LD;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_GATE_A: begin
          if (timer_zero) begin
            state_q   <= ST_SETTLE_B;
            timer_q   <= SETTLE_LD;
            osc_en_q  <= OSC_B;
            count_a_q <= cnt_a_nxt;
            ovf_q[0]  <= ovf_a_nxt;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_SETTLE_B: begin
          if (timer_zero) begin
            state_q <= ST_GATE_B;
            timer_q <= GATE_LD;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_GATE_B: begin
          if (timer_zero) begin
            state_q   <= ST_DONE;
            osc_en_q  <= OSC_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            count_b_q <= cnt_b_nxt;
            ovf_q[1]  <= ovf_b_nxt;
            diff_q    <= {1'b0, count_a_q} - {1'b0, cnt_b_nxt};
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          osc_en_q <= OSC_NONE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign osc_en  = osc_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count_a = count_a_q;
  assign count_b = count_b_q;
  assign ovf     = ovf_q;
  assign diff    = diff_q;

endmodule

// File: tb/tb_osc_measure_ctrl.sv
// Directed bench for osc_measure_ctrl: a 16-bit instance for sequencing,
// abort, reset and continuous mode, plus a 4-bit instance for saturation.
module tb_osc_measure_ctrl;

  localparam int G = 100;
  localparam int S = 4;
  // Edge that first samples done high, counted from the edge that sampled start.
  localparam int LAT = 2 * (S + G) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cont = 1'b0;
  logic        osc_a = 1'b0, osc_b = 1'b0;
  logic [1:0]  osc_en;
  logic        busy, done;
  logic [15:0] count_a, count_b;
  logic [1:0]  ovf;
  logic [16:0] diff;

  logic        start4 = 1'b0, abort4 = 1'b0, cont4 = 1'b0;
  logic        osc_a4 = 1'b0, osc_b4 = 1'b0;
  logic [1:0]  osc_en4;
  logic        busy4, done4;
  logic [3:0]  count_a4, count_b4;
  logic [1:0]  ovf4;
  logic [4:0]  diff4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit both_en_seen = 1'b0;
  int per_a = 4, per_b = 5;

  osc_measure_ctrl #(.CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .osc_a(osc_a), .osc_b(osc_b), .osc_en(osc_en), .busy(busy), .done(done),
    .count_a(count_a), .count_b(count_b), .ovf(ovf), .diff(diff)
  );

  osc_measure_ctrl #(.CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .cont(cont4),
    .osc_a(osc_a4), .osc_b(osc_b4), .osc_en(osc_en4), .busy(busy4), .done(done4),
    .count_a(count_a4), .count_b(count_b4), .ovf(ovf4), .diff(diff4)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (osc_en == 2'b11 || osc_en4 == 2'b11) both_en_seen = 1'b1;
  end

  // Clock-synchronous square waves, updated away from the sampling edge.
  initial begin
    int ph_a = 0, ph_b = 0, ph_a4 = 0, ph_b4 = 0;
    forever begin
      @(negedge clk);
      ph_a  = (ph_a + 1) % per_a;   osc_a  = (ph_a < per_a / 2);
      ph_b  = (ph_b + 1) % per_b;   osc_b  = (ph_b < per_b / 2);
      ph_a4 = (ph_a4 + 1) % 2;      osc_a4 = (ph_a4 < 1);
      ph_b4 = (ph_b4 + 1) % 10;     osc_b4 = (ph_b4 < 5);
    end
  end

  task automatic do_start(output int t0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; at = cyc; end
    end
    checks++;
    if (!seen) begin
      errors++; at = cyc;
      $display("FAIL %s: done not seen within 400 cycles", name);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({osc_en, busy, done, ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {osc_en, busy, done, ovf});
    end
    checks++;
    if ({count_a, count_b, diff} !== 49'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0 0 0", count_a, count_b, diff);
    end
  endtask

  task automatic test_start_abort;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || osc_en !== 2'b00) begin
      errors++; $display("FAIL start_abort: busy %b osc_en %b want 0 00", busy, osc_en);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt !== 0) begin
      errors++; $display("FAIL start_abort_idle: busy %b dones %0d want 0 0", busy, done_cnt);
    end
  endtask

  task automatic test_basic;
    int t0, at;
    do_start(t0);
    checks++;
    if (busy !== 1'b1 || osc_en !== 2'b01) begin
      errors++; $display("FAIL basic_settle_a: busy %b osc_en %b want 1 01", busy, osc_en);
    end
    wait_done("basic_done", at);
    checks++;
    if (at - t0 + 1 !== LAT) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", at - t0 + 1, LAT);
    end
    checks++;
    if (count_a !== 16'd25 || count_b !== 16'd20) begin
      errors++; $display("FAIL basic_counts: got %0d %0d want 25 20", count_a, count_b);
    end
    checks++;
    if (diff !== 17'd5 || ovf !== 2'b00) begin
      errors++; $display("FAIL basic_diff_ovf: got %h %b want 00005 00", diff, ovf);
    end
    checks++;
    if (busy !== 1'b0 || osc_en !== 2'b00) begin
      errors++; $display("FAIL basic_done_ctrl: busy %b osc_en %b want 0 00", busy, osc_en);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_saturate;
    bit seen = 1'b0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL sat_done: done not seen within 400 cycles");
    end
    checks++;
    if (count_a4 !== 4'd15 || count_b4 !== 4'd10) begin
      errors++; $display("FAIL sat_counts: got %0d %0d want 15 10", count_a4, count_b4);
    end
    checks++;
    if (ovf4 !== 2'b01 || diff4 !== 5'd5) begin
      errors++; $display("FAIL sat_ovf_diff: got %b %0d want 01 5", ovf4, diff4);
    end
  endtask

  task automatic test_abort;
    int t0, n;
    do_start(t0);
    repeat (49) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || osc_en !== 2'b00 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy %b osc_en %b done %b want 0 00 0", busy, osc_en, done);
    end
    n = done_cnt;
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt !== n || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: dones %0d busy %b want %0d 0", done_cnt, busy, n);
    end
    checks++;
    if (count_a !== 16'd25 || count_b !== 16'd20 || diff !== 17'd5) begin
      errors++; $display("FAIL abort_retain: got %0d %0d %h want 25 20 00005", count_a, count_b, diff);
    end
  endtask

  task automatic test_reset_gate_b;
    int t0;
    do_start(t0);
    repeat (150) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || osc_en !== 2'b10) begin
      errors++; $display("FAIL gate_b_state: busy %b osc_en %b want 1 10", busy, osc_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({osc_en, busy, done, ovf} !== 6'b0 || {count_a, count_b, diff} !== 49'd0) begin
      errors++; $display("FAIL async_reset: ctrl %b data %h %h %h want all 0",
                         {osc_en, busy, done, ovf}, count_a, count_b, diff);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || osc_en !== 2'b00 || count_a !== 16'd0) begin
      errors++; $display("FAIL reset_idle: busy %b osc_en %b count_a %0d want 0 00 0", busy, osc_en, count_a);
    end
  endtask

  task automatic test_cont;
    int t0, d1, d2, d3, n;
    per_a = 5; per_b = 4;
    cont = 1'b1;
    do_start(t0);
    wait_done("cont_first", d1);
    checks++;
    if (d1 - t0 + 1 !== LAT) begin
      errors++; $display("FAIL cont_latency: got %0d want %0d", d1 - t0 + 1, LAT);
    end
    checks++;
    if (count_a !== 16'd20 || count_b !== 16'd25 || diff !== 17'h1FFFB) begin
      errors++; $display("FAIL cont_neg_diff: got %0d %0d %h want 20 25 1fffb", count_a, count_b, diff);
    end
    // A start while busy must not restart the run.
    repeat (10) @(negedge clk);
    do_start(t0);
    wait_done("cont_second", d2);
    // The DONE cycle precedes each automatic SETTLE_A, so the period is LAT.
    checks++;
    if (d2 - d1 !== LAT) begin
      errors++; $display("FAIL cont_period: got %0d want %0d", d2 - d1, LAT);
    end
    repeat (20) @(negedge clk);
    cont = 1'b0;
    wait_done("cont_last", d3);
    checks++;
    if (d3 - d2 !== LAT || count_b !== 16'd25) begin
      errors++; $display("FAIL cont_finish: period %0d count_b %0d want %0d 25", d3 - d2, count_b, LAT);
    end
    n = done_cnt;
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt !== n || busy !== 1'b0 || osc_en !== 2'b00) begin
      errors++; $display("FAIL cont_park: dones %0d busy %b osc_en %b want %0d 0 00", done_cnt, busy, osc_en, n);
    end
  endtask

  initial begin
    test_reset();
    test_start_abort();
    test_basic();
    test_saturate();
    test_abort();
    test_reset_gate_b();
    test_cont();
    checks++;
    if (both_en_seen !== 1'b0) begin
      errors++; $display("FAIL osc_en_exclusive: got both enables high, want never");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
